// File: rtl/dvsi_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dvsi_scan_ctrl
//  Purpose  : Frame-scan sequencer for the DVSI event-sensor pads. A start
//             trigger walks the sensor through reset, row select, analog
//             sample, column-group scan with xydata/on/off capture, and
//             array reset for every row. Pixel groups with any on/off flag
//             set become 32-bit events in a first-word fall-through FIFO
//             that drains through a valid/ready port.
//  Ports    : clk_i, rst_i (async, active high)
//             start_i                    frame trigger, sampled in IDLE
//             cfg_we_i / cfg_wdata_i     config write, ignored while busy
//             busy_o, frame_done_o       frame status
//             dvsi_*_o                   registered sensor pad controls
//             dvsi_xydata_i, dvsi_on_i, dvsi_off_i   sensor read-back
//             evt_valid_o / evt_ready_i / evt_data_o event stream
//  Revision : 1.0 - initial release
// ============================================================================
module dvsi_scan_ctrl #(
  parameter int NUM_ROWS   = 64,
  parameter int NUM_COLS   = 64,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        cfg_we_i,
  input  logic [7:0]  cfg_wdata_i,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        dvsi_ynrst_o,
  output logic        dvsi_xnrst_o,
  output logic        dvsi_yclk_o,
  output logic        dvsi_xclk_o,
  output logic        dvsi_asa_o,
  output logic        dvsi_are_o,
  output logic        dvsi_asy_o,
  output logic        dvsi_sxy_o,
  output logic [7:0]  dvsi_cfg_o,
  input  logic [7:0]  dvsi_xydata_i,
  input  logic [3:0]  dvsi_on_i,
  input  logic [3:0]  dvsi_off_i,
  output logic        evt_valid_o,
  input  logic        evt_ready_i,
  output logic [31:0] evt_data_o
);

  localparam int c_num_groups = NUM_COLS / 4;
  localparam int c_cw         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int c_aw         = $clog2(FIFO_DEPTH);

  localparam logic [c_cw-1:0] c_cnt_load   = c_cw'(CLK_DIV - 1);
  localparam logic [7:0]      c_last_row   = 8'(NUM_ROWS - 1);
  localparam logic [7:0]      c_last_group = 8'(c_num_groups - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RST       = 4'd1,
    S_YCLK_H    = 4'd2,
    S_YCLK_L    = 4'd3,
    S_ASA       = 4'd4,
    S_XCLK_H    = 4'd5,
    S_XCLK_L    = 4'd6,
    S_SAMPLE    = 4'd7,
    S_WAIT_FIFO = 4'd8,
    S_ARE       = 4'd9,
    S_DONE      = 4'd10
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t          r_state;
  logic [c_cw-1:0] r_cnt;
  logic [7:0]      r_row;
  logic [7:0]      r_group;
  logic [7:0]      r_xy;
  logic [3:0]      r_on;
  logic [3:0]      r_off;
  logic [7:0]      r_cfg;

  logic            r_busy;
  logic            r_frame_done;
  logic            r_ynrst;
  logic            r_xnrst;
  logic            r_yclk;
  logic            r_xclk;
  logic            r_asa;
  logic            r_are;
  logic            r_sxy;

  logic [31:0]     r_mem [FIFO_DEPTH];
  logic [c_aw:0]   r_wr_ptr;
  logic [c_aw:0]   r_rd_ptr;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  state_t          w_state_nxt;
  logic [7:0]      w_row_nxt;
  logic [7:0]      w_group_nxt;
  logic            w_push;
  logic            w_capture;
  logic            w_cnt_done;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_space;
  logic            w_hit;

  logic            w_busy_nxt;
  logic            w_frame_done_nxt;
  logic            w_ynrst_nxt;
  logic            w_xnrst_nxt;
  logic            w_yclk_nxt;
  logic            w_xclk_nxt;
  logic            w_asa_nxt;
  logic            w_are_nxt;
  logic            w_sxy_nxt;

  assign w_cnt_done = (r_cnt == '0);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]) &&
                      (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]);
  assign w_pop      = !w_empty && evt_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_space    = !w_full || w_pop;
  assign w_hit      = |{r_on, r_off};

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_group_nxt = r_group;
    w_push      = 1'b0;
    w_capture   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start_i) w_state_nxt = S_RST;
      end
      S_RST: begin
        if (w_cnt_done) w_state_nxt = S_YCLK_H;
      end
      S_YCLK_H: begin
        if (w_cnt_done) w_state_nxt = S_YCLK_L;
      end
      S_YCLK_L: begin
        if (w_cnt_done) w_state_nxt = S_ASA;
      end
      S_ASA: begin
        if (w_cnt_done) w_state_nxt = S_XCLK_H;
      end
      S_XCLK_H: begin
        if (w_cnt_done) w_state_nxt = S_XCLK_L;
      end
      S_XCLK_L: begin
        if (w_cnt_done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_SAMPLE;
        end
      end
      // WAIT_FIFO is only entered with a nonzero sample held, so it shares
      // the SAMPLE decision and simply repeats it until space appears.
      S_SAMPLE, S_WAIT_FIFO: begin
        if (w_hit && !w_space) begin
          w_state_nxt = S_WAIT_FIFO;
        end else begin
          w_push = w_hit;
          if (r_group == c_last_group) begin
            w_state_nxt = S_ARE;
          end else begin
            w_state_nxt = S_XCLK_H;
            w_group_nxt = r_group + 8'd1;
          end
        end
      end
      S_ARE: begin
        if (w_cnt_done) begin
          w_group_nxt = 8'd0;
          if (r_row == c_last_row) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_YCLK_H;
            w_row_nxt   = r_row + 8'd1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_row_nxt   = 8'd0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pad values for the state being entered; registered so that every pad
  // changes exactly on the state boundary without decode glitches.
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_frame_done_nxt = 1'b0;
    w_ynrst_nxt      = 1'b0;
    w_xnrst_nxt      = 1'b0;
    w_yclk_nxt       = 1'b0;
    w_xclk_nxt       = 1'b0;
    w_asa_nxt        = 1'b0;
    w_are_nxt        = 1'b0;
    w_sxy_nxt        = 1'b0;

    case (w_state_nxt)
      S_YCLK_H: begin
        w_ynrst_nxt = 1'b1;
        w_yclk_nxt  = 1'b1;
      end
      S_YCLK_L: begin
        w_ynrst_nxt = 1'b1;
      end
      S_ASA: begin
        w_ynrst_nxt = 1'b1;
        w_asa_nxt   = 1'b1;
      end
      S_XCLK_H: begin
        w_ynrst_nxt = 1'b1;
        w_xnrst_nxt = 1'b1;
        w_sxy_nxt   = 1'b1;
        w_xclk_nxt  = 1'b1;
      end
      S_XCLK_L, S_SAMPLE, S_WAIT_FIFO: begin
        w_ynrst_nxt = 1'b1;
        w_xnrst_nxt = 1'b1;
        w_sxy_nxt   = 1'b1;
      end
      S_ARE: begin
        w_ynrst_nxt = 1'b1;
        w_are_nxt   = 1'b1;
      end
      S_DONE: begin
        w_frame_done_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = w_busy_nxt;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State, counters and pad registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_row        <= 8'd0;
      r_group      <= 8'd0;
      r_xy         <= 8'd0;
      r_on         <= 4'd0;
      r_off        <= 4'd0;
      r_cfg        <= 8'd0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_ynrst      <= 1'b0;
      r_xnrst      <= 1'b0;
      r_yclk       <= 1'b0;
      r_xclk       <= 1'b0;
      r_asa        <= 1'b0;
      r_are        <= 1'b0;
      r_sxy        <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_group <= w_group_nxt;

      // Half-phase counter: reload on every state change, count down to 0.
      if (w_state_nxt != r_state) begin
        r_cnt <= c_cnt_load;
      end else if (!w_cnt_done) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_capture) begin
        r_xy  <= dvsi_xydata_i;
        r_on  <= dvsi_on_i;
        r_off <= dvsi_off_i;
      end

      if (cfg_we_i && !r_busy) begin
        r_cfg <= cfg_wdata_i;
      end

      r_busy       <= w_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_ynrst      <= w_ynrst_nxt;
      r_xnrst      <= w_xnrst_nxt;
      r_yclk       <= w_yclk_nxt;
      r_xclk       <= w_xclk_nxt;
      r_asa        <= w_asa_nxt;
      r_are        <= w_are_nxt;
      r_sxy        <= w_sxy_nxt;

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Event storage needs no reset; the pointers alone define its contents.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_aw-1:0]] <= {r_row, r_group, r_xy, r_on, r_off};
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy_o       = r_busy;
  assign frame_done_o = r_frame_done;
  assign dvsi_ynrst_o = r_ynrst;
  assign dvsi_xnrst_o = r_xnrst;
  assign dvsi_yclk_o  = r_yclk;
  assign dvsi_xclk_o  = r_xclk;
  assign dvsi_asa_o   = r_asa;
  assign dvsi_are_o   = r_are;
  assign dvsi_asy_o   = 1'b0;
  assign dvsi_sxy_o   = r_sxy;
  assign dvsi_cfg_o   = r_cfg;
  assign evt_valid_o  = !w_empty;
  assign evt_data_o   = r_mem[r_rd_ptr[c_aw-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_dvsi_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dvsi_scan_ctrl
//  Purpose  : Directed self-checking bench for dvsi_scan_ctrl with
//             NUM_ROWS=2, NUM_COLS=8, CLK_DIV=2, FIFO_DEPTH=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dvsi_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        cfg_we_i = 1'b0;
  logic [7:0]  cfg_wdata_i = 8'd0;
  logic        busy_o;
  logic        frame_done_o;
  logic        dvsi_ynrst_o;
  logic        dvsi_xnrst_o;
  logic        dvsi_yclk_o;
  logic        dvsi_xclk_o;
  logic        dvsi_asa_o;
  logic        dvsi_are_o;
  logic        dvsi_asy_o;
  logic        dvsi_sxy_o;
  logic [7:0]  dvsi_cfg_o;
  logic [7:0]  dvsi_xydata_i = 8'd0;
  logic [3:0]  dvsi_on_i = 4'd0;
  logic [3:0]  dvsi_off_i = 4'd0;
  logic        evt_valid_o;
  logic        evt_ready_i = 1'b1;
  logic [31:0] evt_data_o;

  dvsi_scan_ctrl #(
    .NUM_ROWS   (2),
    .NUM_COLS   (8),
    .CLK_DIV    (2),
    .FIFO_DEPTH (2)
  ) u_dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .cfg_we_i      (cfg_we_i),
    .cfg_wdata_i   (cfg_wdata_i),
    .busy_o        (busy_o),
    .frame_done_o  (frame_done_o),
    .dvsi_ynrst_o  (dvsi_ynrst_o),
    .dvsi_xnrst_o  (dvsi_xnrst_o),
    .dvsi_yclk_o   (dvsi_yclk_o),
    .dvsi_xclk_o   (dvsi_xclk_o),
    .dvsi_asa_o    (dvsi_asa_o),
    .dvsi_are_o    (dvsi_are_o),
    .dvsi_asy_o    (dvsi_asy_o),
    .dvsi_sxy_o    (dvsi_sxy_o),
    .dvsi_cfg_o    (dvsi_cfg_o),
    .dvsi_xydata_i (dvsi_xydata_i),
    .dvsi_on_i     (dvsi_on_i),
    .dvsi_off_i    (dvsi_off_i),
    .evt_valid_o   (evt_valid_o),
    .evt_ready_i   (evt_ready_i),
    .evt_data_o    (evt_data_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int t0  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cumulative activity monitor, sampled on the falling edge.
  logic        p_yclk = 1'b0, p_xclk = 1'b0, p_asa = 1'b0, p_are = 1'b0, p_busy = 1'b0;
  int          n_yclk = 0, n_xclk = 0, n_asa = 0, n_are = 0;
  int          h_yclk = 0, h_xclk = 0, h_asa = 0, h_are = 0;
  int          n_overlap = 0, n_asy = 0, n_done = 0;
  int          done_last = 0, busy_first = 0, busy_last = 0;
  logic [31:0] evt_log [32];
  int          evt_n = 0;

  always @(negedge clk) begin
    p_yclk <= dvsi_yclk_o;
    p_xclk <= dvsi_xclk_o;
    p_asa  <= dvsi_asa_o;
    p_are  <= dvsi_are_o;
    p_busy <= busy_o;
    if (dvsi_yclk_o && !p_yclk) n_yclk <= n_yclk + 1;
    if (dvsi_xclk_o && !p_xclk) n_xclk <= n_xclk + 1;
    if (dvsi_asa_o && !p_asa)   n_asa  <= n_asa + 1;
    if (dvsi_are_o && !p_are)   n_are  <= n_are + 1;
    if (dvsi_yclk_o) h_yclk <= h_yclk + 1;
    if (dvsi_xclk_o) h_xclk <= h_xclk + 1;
    if (dvsi_asa_o)  h_asa  <= h_asa + 1;
    if (dvsi_are_o)  h_are  <= h_are + 1;
    if ((int'(dvsi_yclk_o) + int'(dvsi_xclk_o) + int'(dvsi_asa_o) + int'(dvsi_are_o)) > 1)
      n_overlap <= n_overlap + 1;
    if (dvsi_asy_o) n_asy <= n_asy + 1;
    if (frame_done_o) begin
      n_done    <= n_done + 1;
      done_last <= cyc;
    end
    if (busy_o && !p_busy) busy_first <= cyc;
    if (busy_o) busy_last <= cyc;
    if (evt_valid_o && evt_ready_i) begin
      if (evt_n < 32) evt_log[evt_n[4:0]] <= evt_data_o;
      evt_n <= evt_n + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  int b_yclk, b_xclk, b_asa, b_are, b_hy, b_hx, b_ha, b_hr, b_done, b_evt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_yclk = n_yclk; b_xclk = n_xclk; b_asa = n_asa; b_are = n_are;
    b_hy = h_yclk; b_hx = h_xclk; b_ha = h_asa; b_hr = h_are;
    b_done = n_done; b_evt = evt_n;
  endtask

  // Leaves the caller in relative cycle 1, #1 after the clock edge.
  task automatic start_frame();
    @(posedge clk); #1;
    start_i = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // Advance to the falling edge of relative cycle n.
  task automatic goto(input int n);
    @(negedge clk);
    while ((cyc - t0) < n) @(negedge clk);
  endtask

  task automatic chk_four_events(input string tag);
    chk({tag, "_count"}, 32'(evt_n - b_evt), 32'd4);
    chk({tag, "_evt0"}, evt_log[5'(b_evt + 0)], 32'h00005A10);
    chk({tag, "_evt1"}, evt_log[5'(b_evt + 1)], 32'h00015A10);
    chk({tag, "_evt2"}, evt_log[5'(b_evt + 2)], 32'h01005A10);
    chk({tag, "_evt3"}, evt_log[5'(b_evt + 3)], 32'h01015A10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pads", 32'({busy_o, frame_done_o, dvsi_ynrst_o, dvsi_xnrst_o, dvsi_yclk_o,
                          dvsi_xclk_o, dvsi_asa_o, dvsi_are_o, dvsi_asy_o, dvsi_sxy_o}), 32'd0);
    chk("rst_cfg", 32'(dvsi_cfg_o), 32'd0);
    chk("rst_evt_valid", 32'(evt_valid_o), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // ---------------- config write in IDLE ----------------
    @(posedge clk); #1;
    cfg_we_i = 1'b1; cfg_wdata_i = 8'hA5;
    @(posedge clk); #1;
    cfg_we_i = 1'b0; cfg_wdata_i = 8'h00;
    @(negedge clk);
    chk("cfg_idle_write", 32'(dvsi_cfg_o), 32'h000000A5);

    // ---------------- frame 1: no events, cfg write and start while busy ----
    snap();
    start_frame();
    goto(4);
    @(posedge clk); #1;
    cfg_we_i = 1'b1; cfg_wdata_i = 8'h3C;
    @(posedge clk); #1;
    cfg_we_i = 1'b0;
    goto(9);
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    goto(38);
    chk("f1_done_early", 32'(frame_done_o), 32'd0);
    goto(39);
    chk("f1_done_at_39", 32'(frame_done_o), 32'd1);
    chk("f1_busy_at_39", 32'(busy_o), 32'd1);
    goto(45);
    #1;
    chk("f1_busy_first", 32'(busy_first - t0), 32'd1);
    chk("f1_busy_last", 32'(busy_last - t0), 32'd39);
    chk("f1_done_count", 32'(n_done - b_done), 32'd1);
    chk("f1_yclk_pulses", 32'(n_yclk - b_yclk), 32'd2);
    chk("f1_xclk_pulses", 32'(n_xclk - b_xclk), 32'd4);
    chk("f1_asa_pulses", 32'(n_asa - b_asa), 32'd2);
    chk("f1_are_pulses", 32'(n_are - b_are), 32'd2);
    chk("f1_yclk_high", 32'(h_yclk - b_hy), 32'd4);
    chk("f1_xclk_high", 32'(h_xclk - b_hx), 32'd8);
    chk("f1_asa_high", 32'(h_asa - b_ha), 32'd4);
    chk("f1_are_high", 32'(h_are - b_hr), 32'd4);
    chk("f1_no_events", 32'(evt_n - b_evt), 32'd0);
    chk("f1_cfg_held", 32'(dvsi_cfg_o), 32'h000000A5);
    chk("f1_idle_after", 32'(busy_o), 32'd0);

    // ---------------- frame 2: events with consumer always ready ----------
    dvsi_on_i = 4'b0001; dvsi_xydata_i = 8'h5A; evt_ready_i = 1'b1;
    snap();
    start_frame();
    goto(13);
    chk("f2_valid_in_sample", 32'(evt_valid_o), 32'd0);
    goto(14);
    chk("f2_valid_after_push", 32'(evt_valid_o), 32'd1);
    chk("f2_head_data", evt_data_o, 32'h00005A10);
    goto(45);
    #1;
    chk_four_events("f2");
    chk("f2_done_cycle", 32'(done_last - t0), 32'd39);

    // ---------------- frame 3: consumer stalled, FIFO fills ---------------
    evt_ready_i = 1'b0;
    snap();
    start_frame();
    goto(32);
    chk("f3_wait_xclk_low", 32'(dvsi_xclk_o), 32'd0);
    chk("f3_wait_sxy", 32'(dvsi_sxy_o), 32'd1);
    chk("f3_wait_head", evt_data_o, 32'h00005A10);
    goto(99);
    chk("f3_still_stalled", 32'({busy_o, dvsi_xclk_o, evt_valid_o}), 32'b101);
    chk("f3_no_done_yet", 32'(n_done - b_done), 32'd0);
    @(posedge clk); #1;
    evt_ready_i = 1'b1;
    goto(120);
    #1;
    chk_four_events("f3");
    chk("f3_done_cycle", 32'(done_last - t0), 32'd108);
    chk("f3_xclk_pulses", 32'(n_xclk - b_xclk), 32'd4);
    chk("f3_drained", 32'(evt_valid_o), 32'd0);

    // ---------------- frame 4: reset during XCLK_H with 2 events queued ---
    evt_ready_i = 1'b0;
    start_frame();
    goto(27);
    chk("f4_pre_rst", 32'({dvsi_xclk_o, evt_valid_o}), 32'b11);
    rst_i = 1'b1;
    #1;
    chk("f4_rst_valid", 32'(evt_valid_o), 32'd0);
    chk("f4_rst_pads", 32'({busy_o, dvsi_ynrst_o, dvsi_xnrst_o, dvsi_xclk_o,
                             dvsi_sxy_o, dvsi_cfg_o}), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    evt_ready_i = 1'b1;
    snap();
    start_frame();
    goto(45);
    #1;
    chk("f5_busy_first", 32'(busy_first - t0), 32'd1);
    chk("f5_busy_last", 32'(busy_last - t0), 32'd39);
    chk("f5_done_cycle", 32'(done_last - t0), 32'd39);
    chk_four_events("f5");

    chk("pulse_overlap", 32'(n_overlap), 32'd0);
    chk("asy_never_high", 32'(n_asy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
